// File: rtl/rom_sweep_pkg.sv
// Shared encodings for the ROM address sweeper.
package rom_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_ONCE     = 2'd0,
    MODE_WRAP     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/rom_sweep_step.sv
// Next-address and direction calculation for one sweep step.
module rom_sweep_step
  import rom_sweep_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] cur,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W-1:0] last,
  input  logic [ADDR_W-1:0] stride,
  input  dir_e              dir,
  input  mode_e             mode,
  output logic [ADDR_W-1:0] nxt_cur_c,
  output dir_e              nxt_dir_c,
  output logic              end_c
);

  logic [ADDR_W:0] up_sum;
  logic [ADDR_W:0] dn_diff;
  logic            up_ok;
  logic            dn_ok;

  // One extra bit catches carry out of the top and borrow below zero.
  assign up_sum  = {1'b0, cur} + {1'b0, stride};
  assign dn_diff = {1'b0, cur} - {1'b0, stride};
  assign up_ok   = !up_sum[ADDR_W] && (up_sum[ADDR_W-1:0] <= last);
  assign dn_ok   = !dn_diff[ADDR_W] && (dn_diff[ADDR_W-1:0] >= first);

  // Pick the next address; a bounce that cannot move keeps the current one.
  always_comb begin
    nxt_cur_c = cur;
    nxt_dir_c = dir;
    end_c     = 1'b0;
    if (dir == DIR_UP) begin
      if (up_ok) begin
        nxt_cur_c = up_sum[ADDR_W-1:0];
      end else begin
        case (mode)
          MODE_WRAP: nxt_cur_c = first;
          MODE_PINGPONG: begin
            nxt_dir_c = DIR_DOWN;
            if (dn_ok) nxt_cur_c = dn_diff[ADDR_W-1:0];
          end
          default: end_c = 1'b1;
        endcase
      end
    end else begin
      if (dn_ok) begin
        nxt_cur_c = dn_diff[ADDR_W-1:0];
      end else begin
        nxt_dir_c = DIR_UP;
        if (up_ok) nxt_cur_c = up_sum[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rom_sweep.sv
// Sweeps an external async-read ROM over an address range and streams the words out.
module rom_sweep
  import rom_sweep_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] chk
);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] first_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] stride_q;
  mode_e             mode_q;
  dir_e              dir_q;

  logic [ADDR_W-1:0] nxt_cur_c;
  dir_e              nxt_dir_c;
  logic              end_c;

  logic xfer_c;
  logic load_c;
  logic accept_c;
  logic reject_c;
  logic finish_c;

  rom_sweep_step #(
    .ADDR_W (ADDR_W)
  ) u_step (
    .cur       (cur_q),
    .first     (first_q),
    .last      (last_q),
    .stride    (stride_q),
    .dir       (dir_q),
    .mode      (mode_q),
    .nxt_cur_c (nxt_cur_c),
    .nxt_dir_c (nxt_dir_c),
    .end_c     (end_c)
  );

  assign xfer_c   = out_valid & out_ready;
  assign rom_addr = cur_q;

  // Next-state and datapath strobes.
  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    accept_c = 1'b0;
    reject_c = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (first_addr <= last_addr) begin
            accept_c = 1'b1;
            state_d  = ST_RUN;
          end else begin
            reject_c = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_FLUSH;
        end else if (!out_valid || out_ready) begin
          load_c = 1'b1;
          if (end_c) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!out_valid || out_ready) begin
          finish_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Config latch, address cursor, output beat and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q     <= '0;
      first_q   <= '0;
      last_q    <= '0;
      stride_q  <= '0;
      mode_q    <= MODE_ONCE;
      dir_q     <= DIR_UP;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      chk       <= '0;
    end else begin
      err  <= reject_c;
      done <= finish_c;
      busy <= (state_d != ST_IDLE);

      if (accept_c) begin
        first_q  <= first_addr;
        last_q   <= last_addr;
        stride_q <= (stride == '0) ? ADDR_W'(1) : stride;
        mode_q   <= mode_e'(mode);
        cur_q    <= first_addr;
        dir_q    <= DIR_UP;
        chk      <= '0;
      end else if (xfer_c) begin
        chk <= chk ^ out_data;
      end

      if (load_c) begin
        out_addr  <= cur_q;
        out_data  <= rom_data;
        out_valid <= 1'b1;
        cur_q     <= nxt_cur_c;
        dir_q     <= nxt_dir_c;
      end else if (xfer_c) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_sweep.sv
// Directed bench for rom_sweep with a range-list model and a per-cycle beat checker.
module tb_rom_sweep;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] stride;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] chk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int beats    = 0;
  int last_xfer_cyc = 0;
  int unsigned exp_q[$];
  logic [DW-1:0] model_chk = '0;

  logic          prev_ok = 1'b0;
  logic          prev_valid;
  logic          prev_ready;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  rom_sweep #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .stride     (stride),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .chk        (chk)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected beat order derived from the range rules: list the in-range addresses, then
  // play them once, cyclically, or bouncing between the ends without repeating an end.
  task automatic build_exp(input int m, input int f, input int l, input int s);
    int unsigned lst[$];
    int se;
    int idx;
    int d;
    int k;
    exp_q.delete();
    se = (s == 0) ? 1 : s;
    for (int a = f; a <= l && a < 1024; a += se) lst.push_back(a);
    if (m == 1) begin
      for (int i = 0; i < 64; i++) exp_q.push_back(lst[i % lst.size()]);
    end else if (m == 2) begin
      k = lst.size() - 1;
      idx = 0;
      d = 1;
      for (int i = 0; i < 64; i++) begin
        exp_q.push_back(lst[idx]);
        if (k > 0) begin
          if (idx == k) d = -1;
          else if (idx == 0) d = 1;
          idx += d;
        end
      end
    end else begin
      exp_q = lst;
    end
  endtask

  task automatic pin_model(input string name, input int unsigned lit[$]);
    check({name, "_len"}, 64'(exp_q.size() >= lit.size()), 64'd1);
    for (int i = 0; i < lit.size() && i < exp_q.size(); i++) check(name, exp_q[i], lit[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input int m, input int f, input int l, input int s);
    build_exp(m, f, l, s);
    beats      = 0;
    model_chk  = '0;
    mode       = 2'(m);
    first_addr = AW'(f);
    last_addr  = AW'(l);
    stride     = AW'(s);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int maxc);
    for (int i = 0; i < maxc && beats < n; i++) tick();
    check("beats_reached", 64'(beats >= n), 64'd1);
  endtask

  task automatic wait_done(input int maxc, output int dcyc);
    bit found;
    found = 1'b0;
    dcyc  = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        dcyc  = cyc;
        break;
      end
    end
    check("done_seen", 64'(found), 64'd1);
    check("chk_at_done", chk, model_chk);
    check("busy_at_done", busy, 1'b0);
  endtask

  task automatic stop_now(output int b);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    b = beats;
  endtask

  // Every beat is checked against the model; a stalled beat must hold still.
  always @(negedge clk) begin
    int unsigned e;
    if (rst) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok && prev_valid && !prev_ready) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_addr", out_addr, prev_addr);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got addr %0d expected no beat (cycle %0d)", out_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", out_addr, e);
          check("beat_data", out_data, rom_fn(AW'(e)));
          model_chk ^= rom_fn(AW'(e));
        end
        beats++;
        last_xfer_cyc = cyc;
      end
      prev_ok    = 1'b1;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_addr  = out_addr;
      prev_data  = out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int b;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    out_ready  = 1'b1;
    mode       = 2'd0;
    first_addr = '0;
    last_addr  = '0;
    stride     = '0;
    repeat (2) tick();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_chk", chk, 0);
    rst = 1'b0;
    tick();

    // ONCE 0..3 stride 1, exact latency and done timing
    start_sweep(0, 0, 3, 1);
    pin_model("model_once_0_3", '{0, 1, 2, 3});
    check("model_once_0_3_size", exp_q.size(), 4);
    @(negedge clk);
    check("lat_valid_low", out_valid, 0);
    check("lat_busy", busy, 1);
    @(negedge clk);
    check("lat_valid_high", out_valid, 1);
    check("lat_first_addr", out_addr, 0);
    wait_done(20, dc);
    check("done_after_last", dc, last_xfer_cyc + 1);
    check("once_beats", beats, 4);
    check("once_chk_lit", chk, rom_fn(10'd0) ^ rom_fn(10'd1) ^ rom_fn(10'd2) ^ rom_fn(10'd3));
    @(negedge clk);
    check("done_pulse", done, 0);
    tick();

    // WRAP 1020..1023 stride 2, stop mid-run
    start_sweep(1, 1020, 1023, 2);
    pin_model("model_wrap", '{1020, 1022, 1020, 1022, 1020});
    wait_beats(7, 50);
    stop_now(b);
    wait_done(20, dc);
    check("wrap_no_beat_after_stop", beats, b);
    tick();

    // PINGPONG 0..4 stride 2
    start_sweep(2, 0, 4, 2);
    pin_model("model_pp", '{0, 2, 4, 2, 0, 2, 4, 2, 0});
    wait_beats(9, 50);
    stop_now(b);
    wait_done(20, dc);
    check("pp_no_beat_after_stop", beats, b);
    tick();

    // PINGPONG single-address range
    start_sweep(2, 7, 7, 3);
    pin_model("model_pp_single", '{7, 7, 7, 7});
    wait_beats(5, 50);
    stop_now(b);
    wait_done(20, dc);
    tick();

    // Backpressure: ready low for 5 cycles mid-stream
    start_sweep(0, 10, 30, 3);
    pin_model("model_bp", '{10, 13, 16, 19, 22, 25, 28});
    wait_beats(3, 50);
    out_ready = 1'b0;
    repeat (5) tick();
    check("bp_valid_stalled", out_valid, 1);
    check("bp_addr_stalled", out_addr, exp_q[0]);
    out_ready = 1'b1;
    wait_done(50, dc);
    check("bp_beats", beats, 7);
    tick();

    // ONCE range near the top, stride 16
    start_sweep(0, 1000, 1023, 16);
    pin_model("model_top", '{1000, 1016});
    check("model_top_size", exp_q.size(), 2);
    wait_done(20, dc);
    check("top_beats", beats, 2);
    tick();

    // Stride 0 behaves as stride 1
    start_sweep(0, 5, 8, 0);
    pin_model("model_stride0", '{5, 6, 7, 8});
    wait_done(20, dc);
    check("stride0_beats", beats, 4);
    tick();

    // first > last is rejected
    first_addr = AW'(5);
    last_addr  = AW'(2);
    mode       = 2'd0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    tick();
    check("err_cleared", err, 0);
    check("err_busy_after", busy, 0);
    check("err_valid", out_valid, 0);

    // Reset mid-run with a pending beat
    out_ready = 1'b0;
    start_sweep(0, 0, 100, 1);
    repeat (3) tick();
    check("pre_rst_pending", out_valid, 1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    check("mrst_rom_addr", rom_addr, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_out_addr", out_addr, 0);
    check("mrst_out_data", out_data, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err, 0);
    check("mrst_chk", chk, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_done", done, 0);
      check("post_rst_idle", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_sweep.md
ROM_SWEEP -- requirements
Module: rom_sweep

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 32, ROM word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  begin sweep; sampled only in IDLE.
REQ-006 stop  in  1  end sweep early; sampled only in RUN.
REQ-007 mode  in  2  0=ONCE, 1=WRAP, 2=PINGPONG, 3=reserved (behaves as ONCE).
REQ-008 first_addr, last_addr, stride  in  ADDR_W each  sweep range and step; latched on accepted start.
REQ-009 rom_addr  out  ADDR_W  address driven to external async-read ROM.
REQ-010 rom_data  in  DATA_W  ROM word for rom_addr, same cycle.
REQ-011 out_valid/out_ready  out/in  1  beat handshake; transfer when both high on an edge.
REQ-012 out_addr, out_data  out  ADDR_W, DATA_W  beat payload.
REQ-013 busy, done, err, chk  out  1, 1, 1, DATA_W  status; chk = XOR of all transferred out_data since last start.

Function
REQ-014 FSM states SHALL be IDLE, RUN, FLUSH.
REQ-015 IDLE + start with first_addr<=last_addr SHALL latch config, set cur=first_addr, dir=up, clear chk, enter RUN, assert busy.
REQ-016 IDLE + start with first_addr>last_addr SHALL pulse err one cycle and remain IDLE.
REQ-017 Latched stride of 0 SHALL be treated as 1.
REQ-018 rom_addr SHALL equal cur in RUN and hold its last value otherwise.
REQ-019 In RUN, when !out_valid or out_ready, the edge SHALL load out_addr=cur, out_data=rom_data, out_valid=1, and advance cur; otherwise payload and cur SHALL hold.
REQ-020 First beat SHALL be valid on the second edge after the start edge (one RUN cycle latency).
REQ-021 Advance up: n=cur+stride computed ADDR_W+1 wide; in range iff no carry and n<=last.
REQ-022 Out of range: ONCE SHALL enter FLUSH with the loaded beat as final; WRAP SHALL set cur=first; PINGPONG SHALL set dir=down and cur=cur-stride if >=first, else cur.
REQ-023 Advance down (PINGPONG): cur-stride with no borrow and >=first stays in range; otherwise dir=up and cur=cur+stride if in range, else cur.
REQ-024 stop in RUN SHALL enter FLUSH without loading a new beat that edge; a pending beat SHALL still be delivered.
REQ-025 FLUSH SHALL wait until out_valid=0 or the pending beat transfers, then pulse done one cycle, deassert busy, enter IDLE.
REQ-026 chk SHALL update on each transfer edge, including the final beat.
REQ-027 out_valid SHALL never drop without a transfer, except on rst.

Reset
REQ-028 rst SHALL force IDLE, cur=0, dir=up, rom_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0, err=0, chk=0, overriding all inputs including mid-sweep.

Structure
REQ-029 Mode encodings and FSM state encodings SHALL live in a shared package.
REQ-030 Next-address/direction calculation SHALL be a sub-module rom_sweep_step; the ROM itself stays external.

Verification
REQ-031 ONCE 0..3 stride 1, ready=1 -> beats addr 0,1,2,3 back-to-back, done one cycle after beat 3, chk = XOR of the four ROM words.
REQ-032 WRAP 1020..1023 stride 2 -> 1020,1022,1020,1022,...; stop mid-run -> done, no beat after stop edge except pending.
REQ-033 PINGPONG 0..4 stride 2 -> 0,2,4,2,0,2,4; first=last=7 -> 7 repeated.
REQ-034 Backpressure: ready low 5 cycles mid-stream -> out_addr/out_data stable, no address skipped or duplicated.
REQ-035 ONCE 1000..1023 stride 16 -> 1000,1016 then done; stride 0 -> step 1; first=5,last=2 -> err pulse, busy stays 0.
REQ-036 rst asserted mid-RUN with pending beat -> next cycle all outputs at reset values, no done pulse.
